// File: rtl/pcw_pkg.sv
// Shared types and helpers for the PCW ioctl upload responder.
package pcw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DELIVER,
    PREFETCH
  } upl_state_t;

  // Purpose of the outstanding RAM request, decides what its ack does.
  typedef enum logic [1:0] {
    REQ_FETCH,
    REQ_PF,
    REQ_DRAIN
  } req_kind_t;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // 0=256K, 1=512K, 2=1MB, 3=2MB
  function automatic logic [31:0] mem_limit(input logic [1:0] size);
    return 32'd1 << (32'd18 + 32'(size));
  endfunction

endpackage

// File: rtl/upl_prefetch_buf.sv
// One-entry prefetch buffer: data, address tag and valid bit with hit compare.
module upl_prefetch_buf #(
  parameter int unsigned ADDR_W = 21
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clr,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_tag,
  input  logic [7:0]        i_data,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit,
  output logic [7:0]        o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_tag;
  logic [7:0]        r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_data  <= i_data;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_addr);
  assign o_data = r_data;

endmodule

// File: rtl/pcw_mem_uploader.sv
// HPS ioctl upload responder: reads core RAM through a spare arbiter port and
// returns bytes to hps_io, prefetching the next sequential byte.
module pcw_mem_uploader #(
  parameter int unsigned ADDR_W    = 21,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [7:0]  FILL_BYTE = pcw_pkg::FILL_BYTE
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [1:0]        mem_size,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              err,
  output logic [ADDR_W-1:0] bytes_served
);

  import pcw_pkg::*;

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  upl_state_t        r_state, w_state;
  req_kind_t         r_kind, w_kind;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [ADDR_W-1:0] r_bytes, w_bytes;
  logic [7:0]        r_din, w_din;
  logic              r_wait, w_wait;
  logic              r_req, w_req;
  logic              r_err, w_err;
  logic              r_abort, w_abort;
  logic              r_upl_d;
  logic [TMO_W-1:0]  r_tmo, w_tmo;

  logic              w_buf_clr, w_buf_fill, w_buf_hit;
  logic [7:0]        w_buf_data;
  logic [31:0]       w_limit;
  logic [ADDR_W:0]   w_next_a;
  logic              w_rise, w_tmo_hit, w_done, w_accept;
  logic              w_in_range, w_next_ok, w_pf_match, w_abort_now;

  upl_prefetch_buf #(
    .ADDR_W(ADDR_W)
  ) u_buf (
    .i_clk  (clk_sys),
    .i_reset(reset),
    .i_clr  (w_buf_clr),
    .i_fill (w_buf_fill),
    .i_tag  (r_mem_addr),
    .i_data (mem_data),
    .i_addr (ioctl_addr),
    .o_hit  (w_buf_hit),
    .o_data (w_buf_data)
  );

  assign w_limit     = mem_limit(mem_size);
  assign w_rise      = ioctl_upload && !r_upl_d;
  assign w_tmo_hit   = r_req && !mem_ack && (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_done      = r_req && (mem_ack || w_tmo_hit);
  assign w_in_range  = 32'(ioctl_addr) < w_limit;
  // One extra bit so the top address does not wrap past the limit check.
  assign w_next_a    = {1'b0, r_addr} + {{ADDR_W{1'b0}}, 1'b1};
  assign w_next_ok   = 32'(w_next_a) < w_limit;
  assign w_pf_match  = r_req && (r_kind == REQ_PF) && (r_mem_addr == ioctl_addr);
  assign w_accept    = ioctl_rd && !r_wait && ioctl_upload && (r_state != FETCH);
  assign w_abort_now = r_abort || !ioctl_upload;

  always_comb begin
    w_state    = r_state;
    w_kind     = r_kind;
    w_addr     = r_addr;
    w_mem_addr = r_mem_addr;
    w_bytes    = r_bytes;
    w_din      = r_din;
    w_wait     = r_wait;
    w_req      = r_req;
    w_err      = r_err;
    w_abort    = r_abort;
    w_tmo      = r_tmo;
    w_buf_clr  = 1'b0;
    w_buf_fill = 1'b0;

    // The RAM handshake completes independently of which state issued it.
    if (r_req) begin
      if (w_done) begin
        w_req = 1'b0;
        w_tmo = '0;
        if (r_kind == REQ_PF) begin
          if (mem_ack) w_buf_fill = 1'b1;
          else         w_buf_clr  = 1'b1;
        end
      end else begin
        w_tmo = r_tmo + 1'b1;
      end
    end

    if (w_rise) begin
      w_err     = 1'b0;
      w_bytes   = '0;
      w_buf_clr = 1'b1;
    end

    case (r_state)
      IDLE, PREFETCH, DELIVER: begin
        if (r_state == DELIVER) w_bytes = w_bytes + 1'b1;
        if (w_accept) begin
          w_addr = ioctl_addr;
          if (!w_in_range) begin
            w_din   = FILL_BYTE;
            w_state = DELIVER;
          end else if (w_buf_hit && !w_rise) begin
            w_din   = w_buf_data;
            w_state = DELIVER;
          end else if (w_pf_match && mem_ack) begin
            w_din   = mem_data;
            w_state = DELIVER;
          end else if (w_pf_match && !w_done) begin
            w_kind  = REQ_FETCH;
            w_wait  = 1'b1;
            w_state = FETCH;
          end else begin
            w_buf_clr = 1'b1;
            w_wait    = 1'b1;
            w_state   = FETCH;
            if (r_req && !w_done) begin
              w_kind = REQ_DRAIN;
            end else begin
              w_req      = 1'b1;
              w_mem_addr = ioctl_addr;
              w_kind     = REQ_FETCH;
              w_tmo      = '0;
            end
          end
        end else if (r_state == DELIVER) begin
          if (w_next_ok && !r_req && ioctl_upload) begin
            w_req      = 1'b1;
            w_mem_addr = w_next_a[ADDR_W-1:0];
            w_kind     = REQ_PF;
            w_tmo      = '0;
            w_state    = PREFETCH;
          end else begin
            w_state = IDLE;
          end
        end else if (!ioctl_upload) begin
          w_state = IDLE;
          if (r_req && !w_done) w_kind = REQ_DRAIN;
        end
      end

      FETCH: begin
        if (!ioctl_upload) w_abort = 1'b1;
        if (w_done) begin
          if (w_abort_now) begin
            w_wait  = 1'b0;
            w_abort = 1'b0;
            w_state = IDLE;
          end else if (r_kind == REQ_DRAIN) begin
            w_req      = 1'b1;
            w_mem_addr = r_addr;
            w_kind     = REQ_FETCH;
            w_tmo      = '0;
          end else if (mem_ack) begin
            w_din   = mem_data;
            w_wait  = 1'b0;
            w_state = DELIVER;
          end else begin
            w_din   = FILL_BYTE;
            w_err   = 1'b1;
            w_wait  = 1'b0;
            w_state = DELIVER;
          end
        end
      end

      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= IDLE;
      r_kind     <= REQ_FETCH;
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_bytes    <= '0;
      r_din      <= '0;
      r_wait     <= 1'b0;
      r_req      <= 1'b0;
      r_err      <= 1'b0;
      r_abort    <= 1'b0;
      r_upl_d    <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_state    <= w_state;
      r_kind     <= w_kind;
      r_addr     <= w_addr;
      r_mem_addr <= w_mem_addr;
      r_bytes    <= w_bytes;
      r_din      <= w_din;
      r_wait     <= w_wait;
      r_req      <= w_req;
      r_err      <= w_err;
      r_abort    <= w_abort;
      r_upl_d    <= ioctl_upload;
      r_tmo      <= w_tmo;
    end
  end

  assign ioctl_din    = r_din;
  assign ioctl_wait   = r_wait;
  assign mem_req      = r_req;
  assign mem_addr     = r_mem_addr;
  assign err          = r_err;
  assign bytes_served = r_bytes;

endmodule

// File: tb/tb_pcw_mem_uploader.sv
// Directed bench for pcw_mem_uploader with a fixed-latency arbiter model.
module tb_pcw_mem_uploader;

  localparam int ARB_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_size;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [20:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_req;
  logic [20:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        err;
  logic [20:0] bytes_served;

  logic arb_en = 1'b1;
  int   arb_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  pcw_mem_uploader #(
    .ADDR_W   (21),
    .TIMEOUT  (255),
    .FILL_BYTE(8'hFF)
  ) dut (
    .clk_sys     (clk),
    .reset       (reset),
    .mem_size    (mem_size),
    .ioctl_upload(ioctl_upload),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .ioctl_wait  (ioctl_wait),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .err         (err),
    .bytes_served(bytes_served)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_byte(input logic [20:0] a);
    return (a[7:0] + 8'h3C) ^ a[15:8] ^ {3'b000, a[20:16]};
  endfunction

  // Arbiter: acks after the request has been seen for ARB_LAT full cycles.
  always begin
    @(posedge clk);
    #1;
    if (mem_ack) begin
      mem_ack = 1'b0;
      arb_cnt = 0;
    end else if (mem_req && arb_en) begin
      if (arb_cnt == ARB_LAT) begin
        mem_ack  = 1'b1;
        mem_data = ram_byte(mem_addr);
      end else begin
        arb_cnt++;
      end
    end else begin
      arb_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_rd(input logic [20:0] a, output int wc, output logic [7:0] d,
                       output logic req0, output logic [20:0] ma0);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge clk);
    ioctl_rd = 1'b0;
    req0 = mem_req;
    ma0  = mem_addr;
    wc   = 0;
    while (ioctl_wait && wc < 600) begin
      @(negedge clk);
      wc++;
    end
    d = ioctl_din;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          wc;
    logic [7:0]  d;
    logic        rq;
    logic [20:0] ma;

    reset = 1'b1; mem_size = 2'd3; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
    gap(3);
    check("rst_din", ioctl_din, 0);
    check("rst_wait", ioctl_wait, 0);
    check("rst_req", mem_req, 0);
    check("rst_err", err, 0);
    check("rst_bytes", bytes_served, 0);
    reset = 1'b0;
    gap(2);

    // Sequential stream
    ioctl_upload = 1'b1;
    gap(2);
    for (int a = 0; a < 256; a++) begin
      do_rd(21'(a), wc, d, rq, ma);
      check("stream_din", d, ram_byte(21'(a)));
      check("stream_wait", wc, (a == 0) ? 5 : 0);
      gap(10);
    end
    check("stream_bytes", bytes_served, 256);

    // Random jump after prefetch completes
    do_rd(21'h01000, wc, d, rq, ma);
    check("jump1_din", d, ram_byte(21'h01000));
    check("jump1_wait", wc, 5);
    gap(10);
    do_rd(21'h00200, wc, d, rq, ma);
    check("jump2_addr", ma, 21'h00200);
    check("jump2_wait", wc, 5);
    check("jump2_din", d, ram_byte(21'h00200));
    gap(10);

    // Read arriving while the prefetch for that address is in flight
    do_rd(21'h03000, wc, d, rq, ma);
    check("inflt1_din", d, ram_byte(21'h03000));
    do_rd(21'h03001, wc, d, rq, ma);
    check("inflt2_addr", ma, 21'h03001);
    check("inflt2_wait", wc, 4);
    check("inflt2_din", d, ram_byte(21'h03001));
    gap(10);

    // Miss while a prefetch is in flight: drain, then refetch
    do_rd(21'h05000, wc, d, rq, ma);
    check("drain1_wait", wc, 5);
    do_rd(21'h06000, wc, d, rq, ma);
    check("drain2_addr", ma, 21'h05001);
    check("drain2_wait", wc, 10);
    check("drain2_din", d, ram_byte(21'h06000));
    gap(10);
    check("drain_bytes", bytes_served, 262);

    // Range limit with 256K
    mem_size = 2'd0;
    gap(2);
    do_rd(21'h3FFFF, wc, d, rq, ma);
    check("lim_last_din", d, ram_byte(21'h3FFFF));
    gap(1);
    check("lim_last_nopf1", mem_req, 0);
    gap(1);
    check("lim_last_nopf2", mem_req, 0);
    do_rd(21'h40000, wc, d, rq, ma);
    check("oor_wait", wc, 0);
    check("oor_req", rq, 0);
    check("oor_din", d, 8'hFF);
    check("oor_err", err, 0);
    gap(1);
    check("oor_req2", mem_req, 0);

    // Top of address space with 2MB: no wrapped prefetch
    mem_size = 2'd3;
    gap(2);
    do_rd(21'h1FFFFF, wc, d, rq, ma);
    check("top_din", d, ram_byte(21'h1FFFFF));
    gap(1);
    check("top_nopf1", mem_req, 0);
    gap(1);
    check("top_nopf2", mem_req, 0);

    // Timeout
    arb_en = 1'b0;
    do_rd(21'h00010, wc, d, rq, ma);
    arb_en = 1'b1;
    check("tmo_wait", wc, 255);
    check("tmo_din", d, 8'hFF);
    check("tmo_err", err, 1);
    gap(10);
    ioctl_upload = 1'b0;
    gap(3);
    check("tmo_err_sticky", err, 1);
    ioctl_upload = 1'b1;
    gap(2);
    check("rise_err", err, 0);
    check("rise_bytes", bytes_served, 0);

    // Abort: upload falls during FETCH
    do_rd(21'h00020, wc, d, rq, ma);
    check("abort_pre_din", d, ram_byte(21'h00020));
    gap(10);
    @(negedge clk);
    ioctl_addr = 21'h00800;
    ioctl_rd   = 1'b1;
    @(negedge clk);
    ioctl_rd     = 1'b0;
    ioctl_upload = 1'b0;
    wc = 0;
    while (ioctl_wait && wc < 600) begin
      @(negedge clk);
      wc++;
    end
    check("abort_wait", wc, 5);
    check("abort_din", ioctl_din, ram_byte(21'h00020));
    check("abort_bytes", bytes_served, 1);
    gap(1);
    check("abort_req", mem_req, 0);
    do_rd(21'h00900, wc, d, rq, ma);
    check("noupl_wait", wc, 0);
    check("noupl_req", rq, 0);
    check("noupl_din", d, ram_byte(21'h00020));

    // Reset clears the prefetch buffer
    ioctl_upload = 1'b1;
    gap(2);
    do_rd(21'h00A00, wc, d, rq, ma);
    check("rbuf_din", d, ram_byte(21'h00A00));
    gap(10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rbuf_din0", ioctl_din, 0);
    gap(2);
    do_rd(21'h00A01, wc, d, rq, ma);
    check("rbuf_miss_wait", wc, 5);
    check("rbuf_miss_din", d, ram_byte(21'h00A01));

    // Reset while a prefetch request is outstanding
    gap(10);
    do_rd(21'h00B00, wc, d, rq, ma);
    check("rpf_din", d, ram_byte(21'h00B00));
    @(negedge clk);
    check("rpf_req_on", mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rpf_req", mem_req, 0);
    check("rpf_addr", mem_addr, 0);
    check("rpf_wait", ioctl_wait, 0);
    check("rpf_din0", ioctl_din, 0);
    check("rpf_bytes", bytes_served, 0);
    gap(2);
    do_rd(21'h00B01, wc, d, rq, ma);
    check("rpf_miss_wait", wc, 5);
    check("rpf_miss_din", d, ram_byte(21'h00B01));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
